// File: rtl/multi_flex_counter.sv
`default_nettype none
// ============================================================================
// multi_flex_counter: NUM_CHANNELS up/down counters with per-channel range,
// wrap/saturate, rollover flag and wrap pulse. Cascade: MULTI_FLEX_COUNTER_CASCADE_EN
// Revision: 1.0
// ============================================================================
module multi_flex_counter #(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_CNT_BITS = 4,
  parameter int RESET_TO     = 0,
  parameter int CLEAR_TO     = 0,
  parameter int WRAP_TO      = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS-1:0]              clear,
  input  logic [NUM_CHANNELS-1:0]              load,
  input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CHANNELS-1:0]              count_enable,
  input  logic [NUM_CHANNELS-1:0]              count_down,
  input  logic [NUM_CHANNELS-1:0]              saturate,
  input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CHANNELS-1:0]              rollover_flag,
  output logic [NUM_CHANNELS-1:0]              wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] C_RESET_TO = NUM_CNT_BITS'(RESET_TO);
  localparam logic [NUM_CNT_BITS-1:0] C_CLEAR_TO = NUM_CNT_BITS'(CLEAR_TO);
  localparam logic [NUM_CNT_BITS-1:0] C_WRAP_TO  = NUM_CNT_BITS'(WRAP_TO);
  localparam logic [NUM_CNT_BITS-1:0] C_ONE      = NUM_CNT_BITS'(1);

  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CHANNELS-1:0]              flag_q, flag_d;
  logic [NUM_CHANNELS-1:0]              wrap_q, wrap_d;

  logic [NUM_CNT_BITS-1:0] w_cur;
  logic [NUM_CNT_BITS-1:0] w_rv;
  logic [NUM_CNT_BITS-1:0] w_nxt;
  logic                    w_en;
  logic                    w_at_bound;
  logic                    w_wrap_evt;
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
  logic                    w_carry;
`endif

  always_comb begin
    count_d    = count_q;
    flag_d     = '0;
    wrap_d     = '0;
    w_cur      = '0;
    w_rv       = '0;
    w_nxt      = '0;
    w_en       = 1'b0;
    w_at_bound = 1'b0;
    w_wrap_evt = 1'b0;
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
    w_carry    = 1'b1;
`endif
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_cur      = count_q[i*NUM_CNT_BITS +: NUM_CNT_BITS];
      w_rv       = rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
      w_nxt      = w_cur;
      w_wrap_evt = 1'b0;
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
      // Channel i steps only when the lower digit wraps in this same cycle.
      w_en       = count_enable[i] & w_carry;
`else
      w_en       = count_enable[i];
`endif
      // A degenerate range (bound below WRAP_TO) is treated as always at the boundary.
      w_at_bound = (w_rv < C_WRAP_TO) ||
                   (count_down[i] ? (w_cur <= C_WRAP_TO) : (w_cur >= w_rv));
      if (clear[i]) begin
        w_nxt = C_CLEAR_TO;
      end else if (load[i]) begin
        w_nxt = load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
      end else if (w_en) begin
        if (w_at_bound) begin
          if (!saturate[i]) begin
            w_nxt      = count_down[i] ? w_rv : C_WRAP_TO;
            w_wrap_evt = 1'b1;
          end
        end else begin
          w_nxt = count_down[i] ? (w_cur - C_ONE) : (w_cur + C_ONE);
        end
      end
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
      w_carry = w_wrap_evt;
`endif
      count_d[i*NUM_CNT_BITS +: NUM_CNT_BITS] = w_nxt;
      flag_d[i] = (w_nxt == w_rv);
      wrap_d[i] = w_wrap_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {NUM_CHANNELS{C_RESET_TO}};
      flag_q  <= '0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = wrap_q;

endmodule
`default_nettype wire

// File: doc/multi_flex_counter.md
# multi_flex_counter

Parameterised multi-channel successor to the single flexible counter. It provides NUM_CHANNELS independent up/down counters with per-channel rollover value, synchronous load, wrap or saturate mode, a level rollover flag and a one-cycle wrap pulse. Channels can optionally be cascaded into one multi-digit counter. It serves the AES datapath control (round, byte and word sequencing) wherever more than one related count is needed.

## Interface
- NUM_CHANNELS, 4: number of independent counter channels (≥1).
- NUM_CNT_BITS, 4: width of each channel's count.
- RESET_TO, 0: count value after reset.
- CLEAR_TO, 0: count value after a clear.
- WRAP_TO, 1: low bound of the count range; the value loaded on an up-wrap.

Ports. Vector ports pack channel i at bits [i*NUM_CNT_BITS +: NUM_CNT_BITS] or bit [i].
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  NUM_CHANNELS  synchronous clear per channel.
- load  in  NUM_CHANNELS  synchronous load of load_val.
- load_val  in  NUM_CHANNELS*NUM_CNT_BITS  load value.
- count_enable  in  NUM_CHANNELS  step enable.
- count_down  in  NUM_CHANNELS  1 = decrement, 0 = increment.
- saturate  in  NUM_CHANNELS  1 = hold at the range boundary, 0 = wrap.
- rollover_val  in  NUM_CHANNELS*NUM_CNT_BITS  upper bound of the count range.
- count_out  out  NUM_CHANNELS*NUM_CNT_BITS  current count, registered.
- rollover_flag  out  NUM_CHANNELS  registered; high while the count equals rollover_val.
- wrap_pulse  out  NUM_CHANNELS  registered one-cycle pulse on a wrap.

## Operation
- Reset (rst=1, any time, including mid-count): every count_out = RESET_TO, rollover_flag = 0, wrap_pulse = 0. The block leaves reset on the first clk edge after rst falls.
- Per channel, the effective enable is en. Without cascade, en = count_enable[i]. Next-count priority, evaluated each cycle:
  1. clear: CLEAR_TO.
  2. load: load_val (taken as-is, even if outside the range).
  3. en and up (count_down=0):
     - if count ≥ rollover_val: WRAP_TO when wrapping, or hold when saturating;
     - else count+1.
  4. en and down (count_down=1):
     - if count ≤ WRAP_TO: rollover_val when wrapping, or hold when saturating;
     - else count−1.
  5. Otherwise: hold.
- Wrap event (combinational, internal): en is high, clear and load are low, saturate=0, and the boundary condition in rule 3 or 4 is true.
- wrap_pulse[i] is the wrap event registered. It is never asserted in saturate mode.
- rollover_flag[i] is (next count == rollover_val[i]), registered every cycle (not gated by enable).
- Arithmetic is NUM_CNT_BITS wide, unsigned. Because the boundary compare uses ≥ and ≤, the count can never step past the range.
- Degenerate range (rollover_val < WRAP_TO): an up-step always lands on WRAP_TO and a down-step always lands on rollover_val. This behaviour is deterministic and must not be flagged as an error.
- Simultaneous events:
  - clear beats load, and load beats count.
  - clear or load in the same cycle as a boundary step suppresses wrap_pulse.
- Changing rollover_val mid-count takes effect on the next compare. A count that ends up above the new bound wraps on its next up-step.

## Timing
- All outputs are registered, with one-cycle latency from input to count_out, rollover_flag and wrap_pulse.
- wrap_pulse is coincident with the cycle in which count_out shows the wrapped value. It lasts exactly one cycle per event; back-to-back events give a continuous high level.
- rollover_flag reflects the rollover_val sampled at the previous edge.
- No handshake: inputs are sampled every edge.

## Configuration
- MULTI_FLEX_COUNTER_CASCADE_EN defined:
  - For i>0, en[i] = count_enable[i] AND wrap event of channel i−1 in the same cycle (combinational, no added latency).
  - Channel 0 uses count_enable[0] directly.
  - The channels form a mixed-radix counter, least significant digit = channel 0.
- Not defined: all channels are fully independent, en[i] = count_enable[i].
- Ports and reset behaviour are identical in both builds.

## Test plan
- Reset mid-count: channel 0 counting at 5, assert rst between edges → count_out[0] = RESET_TO = 0 immediately; flag and pulse 0; counting resumes from 0 one edge after rst falls.
- Up-wrap: rollover_val = 3, WRAP_TO = 1, enable held from count 1 → sequence 1,2,3,1,2. rollover_flag is high while the count is 3. wrap_pulse is high only in the cycle the count shows 1 after the 3.
- Down and saturate: rollover_val = 9, count_down = 1, saturate = 1, load 3 → 3,2,1,1,1. wrap_pulse stays 0. Then saturate = 0 → next step gives 9 with wrap_pulse = 1.
- Priority: clear, load (load_val = 7) and enable all high at count = rollover_val → count = CLEAR_TO = 0, no wrap_pulse, rollover_flag = 0. Load alone with load_val = 7 and rollover_val = 7 → count 7, flag 1.
- Bound change: count 8, rollover_val drops to 5, up-step → count = 1 with wrap_pulse = 1.
- Cascade (macro defined, 2 channels, both rollover_val = 2, WRAP_TO = 1, both enables high) → channel 0 sequence 1,2,1,2,1. Channel 1 increments only on channel 0's wraps: 1,1,2,2,1 (starting from 1). Macro undefined → both channels step every cycle.
